// File: rtl/prog_counter_pkg.sv
// ============================================================================
// Module      : prog_counter_pkg
// Description : Count-mode encoding and terminal-value helper for prog_counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_counter_pkg;

    typedef enum logic [1:0] {
        UP_WRAP    = 2'b00,
        DN_WRAP    = 2'b01,
        UP_SAT     = 2'b10,
        DN_ONESHOT = 2'b11
    } cnt_mode_e;

    localparam int unsigned TERM_W = 32;

    // Terminal value for a counter of the given width (up modes: all ones, down modes: zero).
    function automatic logic [TERM_W-1:0] terminal_of(input cnt_mode_e mode, input int unsigned width);
        logic [TERM_W-1:0] ones;
        ones = '1;
        if ((mode == UP_WRAP) || (mode == UP_SAT)) begin
            return ones >> (TERM_W - width);
        end
        return '0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module      : tick_prescaler
// Description : Enable-gated divider; step fires once every presc+1 enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    output logic               step
);

    logic [PRESC_W-1:0] r_pc;

    // >= compare so a divisor lowered below the running count fires immediately.
    assign step = en && (r_pc >= presc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else if (step) begin
            r_pc <= '0;
        end else if (en) begin
            r_pc <= r_pc + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/prog_counter.sv
// ============================================================================
// Module      : prog_counter
// Description : Prescaled up/down counter with four modes and tick/wrap pulses.
//               Optional compare output enabled by PROG_COUNTER_MATCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   cnt,
    output logic               tick,
    output logic               wrap,
    output logic               active
`ifdef PROG_COUNTER_MATCH_EN
    ,
    input  logic [WIDTH-1:0]   cmp_val,
    output logic               match
`endif
);

    localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_cnt;
    logic             r_tick;
    logic             r_wrap;
    logic             w_step;
    logic             w_presc_rst;
    logic             w_adv;
    logic             w_wrap;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_term;
    cnt_mode_e        w_mode;

    assign w_mode      = cnt_mode_e'(mode);
    assign w_term      = WIDTH'(terminal_of(w_mode, WIDTH));
    // A load restarts the prescale period as well as the count.
    assign w_presc_rst = rst | load;

    tick_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .rst   (w_presc_rst),
        .en    (en),
        .presc (presc),
        .step  (w_step)
    );

    always_comb begin
        w_adv  = 1'b0;
        w_wrap = 1'b0;
        w_nxt  = r_cnt;
        case (w_mode)
            UP_WRAP: begin
                w_adv  = 1'b1;
                w_nxt  = r_cnt + 1'b1;
                w_wrap = (r_cnt == C_MAX);
            end
            DN_WRAP: begin
                w_adv  = 1'b1;
                w_nxt  = r_cnt - 1'b1;
                w_wrap = (r_cnt == '0);
            end
            UP_SAT: begin
                if (r_cnt != C_MAX) begin
                    w_adv  = 1'b1;
                    w_nxt  = r_cnt + 1'b1;
                    w_wrap = (r_cnt == (C_MAX - 1'b1));
                end
            end
            DN_ONESHOT: begin
                if (r_cnt != '0) begin
                    w_adv  = 1'b1;
                    w_nxt  = r_cnt - 1'b1;
                    w_wrap = (r_cnt == WIDTH'(1));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_cnt  <= load_val;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (w_step && w_adv) begin
            r_cnt  <= w_nxt;
            r_tick <= 1'b1;
            r_wrap <= w_wrap;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

`ifdef PROG_COUNTER_MATCH_EN
    logic r_match;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_match <= 1'b0;
        end else begin
            r_match <= w_step && w_adv && (w_nxt == cmp_val);
        end
    end

    assign match = r_match;
`endif

    assign cnt    = r_cnt;
    assign tick   = r_tick;
    assign wrap   = r_wrap;
    assign active = (r_cnt != w_term);

endmodule

`default_nettype wire
